// File: rtl/key_debounce_encoder.sv
// Keypad front end: 2-FF synchroniser, highest-index priority encoder, press/release
// debounce FSM with optional auto-repeat, and a one-entry valid/ready event register.
module key_debounce_encoder #(
  parameter int N_KEYS       = 10,
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_CYC   = 0,
  localparam int CODE_W      = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] S_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_rpt,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              GS,
  output logic              ovf
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    HELD,
    RELEASE
  } state_t;

  // Key lines are asynchronous; two flops before any decision logic sees them.
  logic [N_KEYS-1:0] sync_q1, sync_q2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= S_n;
      sync_q2 <= sync_q1;
    end
  end

  logic [N_KEYS-1:0] pressed;
  logic              any_key;
  logic [CODE_W-1:0] cand;

  assign pressed = ~sync_q2;
  assign any_key = |pressed;

  // Ascending scan: the last hit is the highest pressed index.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (pressed[i]) cand = CODE_W'(i);
    end
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RPT_W-1:0]  rcnt_q, rcnt_d;
  logic [CODE_W-1:0] latched_q, latched_d;
  logic              issue, issue_rpt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      latched_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      latched_q <= latched_d;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    latched_d = latched_q;
    issue     = 1'b0;
    issue_rpt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_key) begin
          state_d   = CHECK;
          latched_d = cand;
          cnt_d     = '0;
        end
      end
      CHECK: begin
        if (!any_key) begin
          state_d = IDLE;
        end else if (cand != latched_q) begin
          latched_d = cand;
          cnt_d     = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          issue   = 1'b1;
          rcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!any_key) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (cand != latched_q) begin
          state_d   = CHECK;
          latched_d = cand;
          cnt_d     = '0;
        end else if (REPEAT_CYC > 0) begin
          if (rcnt_q == RPT_MAX) begin
            issue     = 1'b1;
            issue_rpt = 1'b1;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        // A same-key return inside the window is bounce: back to HELD silently.
        if (any_key) begin
          if (cand == latched_q) begin
            state_d = HELD;
            rcnt_d  = '0;
          end else begin
            state_d   = CHECK;
            latched_d = cand;
            cnt_d     = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry event register: a new event may replace data only if the slot is
  // empty or being drained on this same edge; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= '0;
      key_rpt   <= 1'b0;
      key_valid <= 1'b0;
      ovf       <= 1'b0;
      GS        <= 1'b0;
    end else begin
      GS <= (state_d == HELD) || (state_d == RELEASE);
      if (issue) begin
        if (!key_valid || key_ready) begin
          key_code  <= latched_q;
          key_rpt   <= issue_rpt;
          key_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Randomised scoreboard bench: two DUTs (repeat off / repeat every 20 clocks) share the
// stimulus; a run-length reference model predicts events, a negedge monitor checks them.
module tb_key_debounce_encoder;

  localparam int N = 10;
  localparam int D = 4;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] code;
    logic         rpt;
  } ev_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] S_n;
  logic         key_ready;

  logic [W-1:0] c0, c1;
  logic         r0, r1, v0, v1, gs0, gs1, ov0, ov1;

  key_debounce_encoder #(.N_KEYS(N), .DEBOUNCE_CYC(D), .REPEAT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .S_n(S_n), .key_code(c0), .key_rpt(r0),
    .key_valid(v0), .key_ready(key_ready), .GS(gs0), .ovf(ov0)
  );

  key_debounce_encoder #(.N_KEYS(N), .DEBOUNCE_CYC(D), .REPEAT_CYC(20)) dut1 (
    .clk(clk), .rst(rst), .S_n(S_n), .key_code(c1), .key_rpt(r1),
    .key_valid(v1), .key_ready(key_ready), .GS(gs1), .ovf(ov1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ev_t          q0[$], q1[$];
  logic [N-1:0] p1 = '1, p2 = '1;
  int           prev_x = -1, run = 0;
  bit           m_held[2], m_full[2], m_ovf[2];
  int           m_h[2], m_streak[2];

  function automatic int top_key(logic [N-1:0] v);
    int k = -1;
    for (int i = 0; i < N; i++) if (!v[i]) k = i;
    return k;
  endfunction

  function automatic int rep_of(int d);
    return (d == 0) ? 0 : 20;
  endfunction

  // x: highest key seen by the design this cycle (-1 none); run: length of its streak.
  task automatic model_step(int d, int x, int prev);
    bit  ev, rpt, hs;
    ev_t e;
    ev  = 1'b0;
    rpt = 1'b0;
    if (!m_held[d]) begin
      if (x >= 0 && run == D + 1) begin
        ev = 1'b1; m_held[d] = 1'b1; m_h[d] = x; m_streak[d] = 0;
      end
    end else if (x == m_h[d]) begin
      if (prev == m_h[d]) begin
        m_streak[d]++;
        if (rep_of(d) > 0 && m_streak[d] == rep_of(d)) begin
          ev = 1'b1; rpt = 1'b1; m_streak[d] = 0;
        end
      end else begin
        m_streak[d] = 0;
      end
    end else if (x < 0) begin
      if (run == D + 1) m_held[d] = 1'b0;
    end else begin
      m_held[d] = 1'b0;
    end
    hs = m_full[d] && key_ready;
    if (ev) begin
      if (!m_full[d] || hs) begin
        e.code = W'(m_h[d]);
        e.rpt  = rpt;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        m_full[d] = 1'b1;
      end else begin
        m_ovf[d] = 1'b1;
      end
    end else if (hs) begin
      m_full[d] = 1'b0;
    end
  endtask

  always @(posedge clk) begin : model
    int x, prev;
    if (rst) begin
      p1 = '1; p2 = '1; prev_x = -1; run = 0;
      q0.delete(); q1.delete();
      for (int d = 0; d < 2; d++) begin
        m_held[d] = 0; m_full[d] = 0; m_ovf[d] = 0; m_h[d] = 0; m_streak[d] = 0;
      end
    end else begin
      x  = top_key(p2);
      p2 = p1;
      p1 = S_n;
      prev = prev_x;
      run  = (x == prev_x) ? run + 1 : 1;
      prev_x = x;
      for (int d = 0; d < 2; d++) model_step(d, x, prev);
    end
  end

  // ---------------- monitor ----------------
  task automatic check_dut(int d, logic v, logic [W-1:0] c, logic rp, logic g, logic o);
    ev_t e;
    int  qs;
    check($sformatf("valid%0d", d), v, m_full[d]);
    check($sformatf("gs%0d", d), g, m_held[d]);
    check($sformatf("ovf%0d", d), o, m_ovf[d]);
    if (v) begin
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL event%0d: unexpected event code=%0d rpt=%0b, none expected", d, c, rp);
      end else begin
        e = (d == 0) ? q0[0] : q1[0];
        check($sformatf("code%0d", d), c, e.code);
        check($sformatf("rpt%0d", d), rp, e.rpt);
        if (key_ready) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_dut(0, v0, c0, r0, gs0, ov0);
      check_dut(1, v1, c1, r1, gs1, ov1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_seg(logic [N-1:0] pat, int len, int rmode);
    S_n = pat;
    for (int i = 0; i < len; i++) begin
      case (rmode)
        0:       key_ready = 1'b1;
        1:       key_ready = 1'($urandom_range(0, 1));
        default: key_ready = 1'b0;
      endcase
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_valid0"}, v0, 0);
    check({tag, "_gs0"}, gs0, 0);
    check({tag, "_ovf0"}, ov0, 0);
    check({tag, "_code0"}, c0, 0);
    check({tag, "_rpt0"}, r0, 0);
    check({tag, "_valid1"}, v1, 0);
    check({tag, "_ovf1"}, ov1, 0);
    check({tag, "_code1"}, c1, 0);
  endtask

  initial begin
    logic [N-1:0] one, pat;
    int           kind, len, rmode;
    one       = 10'd1;
    rst       = 1'b1;
    S_n       = '1;
    key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    run_seg(10'h3FF, 20, 0);
    check_reset_outputs("idle");

    run_seg(10'h3DF, 12, 0);                 // key5 press
    run_seg(10'h3FF, 12, 0);
    run_seg(10'h3D6, 15, 0);                 // keys 0,3,5 -> 5
    run_seg(10'h3F6, 15, 0);                 // drop 5 -> 3
    run_seg(10'h3FF, 12, 0);
    run_seg(10'h3DF, 3, 0);                  // short glitch
    run_seg(10'h3FF, 10, 0);
    run_seg(10'h3DF, 12, 0);                 // press, then bounce during release
    run_seg(10'h3FF, 3, 0);
    run_seg(10'h3DF, 12, 0);
    run_seg(10'h3FF, 12, 0);
    run_seg(10'h1FF, 100, 0);                // key9 held: repeats on dut1
    run_seg(10'h3FF, 12, 0);
    run_seg(10'h3FB, 12, 2);                 // key2, consumer stalled
    run_seg(10'h3FF, 12, 2);
    run_seg(10'h37F, 12, 2);                 // key7 dropped -> ovf
    run_seg(10'h3FF, 12, 2);
    run_seg(10'h3FF, 5, 0);
    run_seg(10'h3F7, 4, 0);                  // key3 reaches CHECK
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outputs("rst_mid");
    check("rst_mid_gs1", gs1, 0);
    rst = 1'b0;

    for (int s = 0; s < 350; s++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 2)      pat = '1;
      else if (kind <= 6) pat = ~(one << $urandom_range(0, N - 1));
      else if (kind <= 8) pat = N'($urandom) | N'($urandom);
      else                pat = S_n & ~(one << $urandom_range(0, N - 1));
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, D - 1);
        1:       len = $urandom_range(D, D + 2);
        default: len = $urandom_range(D + 3, 40);
      endcase
      rmode = ($urandom_range(0, 9) < 6) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
      end
      run_seg(pat, len, rmode);
    end

    run_seg(10'h3FF, 40, 0);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("drain_valid0", v0, 0);
    check("drain_valid1", v1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
